axis_video_frame_checker: RTL and testbench

Synthesizable, parametrised AXI4-Stream video frame monitor that passively taps a capture block's master stream (tvalid/tready/tuser/tlast/tdata) and checks frame and line structure against programmed geometry. It generalises the bench-side SOF/line-interval checks into RTL with any tdata width, runtime-programmable line and frame size, saturating error counters and a per-frame data signature. It sits beside the capture core's M00_AXIS output, and its status is read through the core's AXI-Lite register file.

---
 rtl/axis_video_frame_checker.sv | 130 +++++++++++++
 tb/tb_axis_video_frame_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axis_video_frame_checker.sv
// axis_video_frame_checker: passive AXI4-Stream video tap that checks SOF/line/frame structure
// against programmed geometry, with saturating error counters and a per-frame XOR signature.
module axis_video_frame_checker #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tuser,
  input  logic                              s00_axis_tlast,
  input  logic                              enable_i,
  input  logic                              clear_i,
  input  logic [C_CNT_WIDTH-1:0]            line_beats_i,
  input  logic [C_CNT_WIDTH-1:0]            frame_lines_i,
  output logic [C_CNT_WIDTH-1:0]            frame_count_o,
  output logic [C_CNT_WIDTH-1:0]            sof_err_count_o,
  output logic [C_CNT_WIDTH-1:0]            line_err_count_o,
  output logic                              err_o,
  output logic [C_CNT_WIDTH-1:0]            last_line_beats_o,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] signature_o,
  output logic [1:0]                        state_o
);
  localparam int DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int CW = C_CNT_WIDTH;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, IN_FRAME = 2'd2} state_t;
  state_t state_q, state_d;
  logic synced_q, synced_d, overrun_q, overrun_d, err_q, err_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, line_cnt_q, line_cnt_d;
  logic [CW-1:0] frame_q, frame_d, sof_err_q, sof_err_d, line_err_q, line_err_d, last_q, last_d;
  logic [DW-1:0] acc_q, acc_d, sig_q, sig_d;
  logic beat, in_frame, take, sof_inc, line_inc, frame_inc;
  logic [CW-1:0] nb, nl, nl1;
  logic [DW-1:0] nacc;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return &x ? x : x + CW'(1);
  endfunction
  always_comb begin
    state_d = state_q;
    synced_d = synced_q;
    overrun_d = overrun_q;
    beat_cnt_d = beat_cnt_q;
    line_cnt_d = line_cnt_q;
    acc_d = acc_q;
    last_d = last_q;
    sig_d = sig_q;
    sof_inc = 1'b0;
    line_inc = 1'b0;
    frame_inc = 1'b0;
    beat = s00_axis_tvalid && s00_axis_tready;
    in_frame = state_q == IN_FRAME;
    take = beat && (in_frame || (state_q == WAIT_SOF && s00_axis_tuser));
    // a tuser beat always opens a fresh frame, so the running values restart from it
    nb = s00_axis_tuser ? CW'(1) : sat_inc(beat_cnt_q);
    nl = s00_axis_tuser ? '0 : line_cnt_q;
    nacc = s00_axis_tuser ? s00_axis_tdata : acc_q ^ s00_axis_tdata;
    nl1 = sat_inc(nl);
    if (!enable_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d = WAIT_SOF;
    end else if (take) begin
      sof_inc = in_frame && s00_axis_tuser;
      overrun_d = 1'b0;
      state_d = IN_FRAME;
      beat_cnt_d = nb;
      line_cnt_d = nl;
      acc_d = nacc;
      if (s00_axis_tlast) begin
        last_d = nb;
        line_inc = nb != line_beats_i;
        line_cnt_d = nl1;
        beat_cnt_d = '0;
        if (nl1 == frame_lines_i) begin
          frame_inc = 1'b1;
          sig_d = nacc;
          synced_d = 1'b1;
          state_d = WAIT_SOF;
        end
      end
    end else if (beat && state_q == WAIT_SOF && synced_q && !overrun_q) begin
      sof_inc = 1'b1;
      overrun_d = 1'b1;
    end
    frame_d = clear_i ? '0 : frame_inc ? sat_inc(frame_q) : frame_q;
    sof_err_d = clear_i ? '0 : sof_inc ? sat_inc(sof_err_q) : sof_err_q;
    line_err_d = clear_i ? '0 : line_inc ? sat_inc(line_err_q) : line_err_q;
    err_d = !clear_i && (err_q || sof_inc || line_inc);
    last_d = clear_i ? '0 : last_d;
    sig_d = clear_i ? '0 : sig_d;
  end
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q <= IDLE;
      synced_q <= 1'b0;
      overrun_q <= 1'b0;
      err_q <= 1'b0;
      beat_cnt_q <= '0;
      line_cnt_q <= '0;
      frame_q <= '0;
      sof_err_q <= '0;
      line_err_q <= '0;
      last_q <= '0;
      acc_q <= '0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      synced_q <= synced_d;
      overrun_q <= overrun_d;
      err_q <= err_d;
      beat_cnt_q <= beat_cnt_d;
      line_cnt_q <= line_cnt_d;
      frame_q <= frame_d;
      sof_err_q <= sof_err_d;
      line_err_q <= line_err_d;
      last_q <= last_d;
      acc_q <= acc_d;
      sig_q <= sig_d;
    end
  end
  assign frame_count_o = frame_q;
  assign sof_err_count_o = sof_err_q;
  assign line_err_count_o = line_err_q;
  assign err_o = err_q;
  assign last_line_beats_o = last_q;
  assign signature_o = sig_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_axis_video_frame_checker.sv
// tb_axis_video_frame_checker: directed scenario tasks for the frame checker, 10x10 geometry.
module tb_axis_video_frame_checker;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic tvalid = 1'b0, tready = 1'b1, tuser = 1'b0, tlast = 1'b0;
  logic [63:0] tdata = '0;
  logic enable = 1'b0, clear = 1'b0;
  logic [31:0] line_beats = 32'd10, frame_lines = 32'd10;
  logic [31:0] frame_count, sof_err, line_err, last_beats;
  logic err;
  logic [63:0] signature;
  logic [1:0] state;
  logic [63:0] sig_m = '0;
  bit rand_ready = 1'b0;
  int vectors = 0, miscompares = 0;

  axis_video_frame_checker #(.C_S00_AXIS_TDATA_WIDTH(64), .C_CNT_WIDTH(32)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(aresetn), .s00_axis_tvalid(tvalid),
    .s00_axis_tready(tready), .s00_axis_tdata(tdata), .s00_axis_tuser(tuser),
    .s00_axis_tlast(tlast), .enable_i(enable), .clear_i(clear),
    .line_beats_i(line_beats), .frame_lines_i(frame_lines),
    .frame_count_o(frame_count), .sof_err_count_o(sof_err), .line_err_count_o(line_err),
    .err_o(err), .last_line_beats_o(last_beats), .signature_o(signature), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input bit sof, input bit tl);
    logic [63:0] d;
    bit r;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      tdata = d;
      tuser = sof && i == 0;
      tlast = tl && i == n - 1;
      tvalid = 1'b1;
      sig_m ^= d;
      do begin
        r = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        tready = r;
        tick();
      end while (!r);
    end
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic send_frame();
    sig_m = '0;
    for (int l = 0; l < 10; l++) send_line(10, l == 0, 1'b1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    if (frame_count !== 0) begin $display("FAIL reset_frames got %0d want 0", frame_count); miscompares++; end vectors++;
    if (sof_err !== 0 || line_err !== 0) begin $display("FAIL reset_errs got %0d/%0d want 0/0", sof_err, line_err); miscompares++; end vectors++;
    if (err !== 1'b0 || last_beats !== 0 || signature !== 0) begin $display("FAIL reset_misc got err=%b last=%0d sig=%h want 0", err, last_beats, signature); miscompares++; end vectors++;
    if (state !== 2'd0) begin $display("FAIL reset_state got %0d want 0", state); miscompares++; end vectors++;
    aresetn = 1'b1;
    enable = 1'b1;
    tick();
    if (state !== 2'd1) begin $display("FAIL enable_state got %0d want 1", state); miscompares++; end vectors++;
  endtask

  task automatic test_clean();
    rand_ready = 1'b1;
    repeat (3) send_frame();
    rand_ready = 1'b0;
    if (frame_count !== 3) begin $display("FAIL clean_frames got %0d want 3", frame_count); miscompares++; end vectors++;
    if (sof_err !== 0 || line_err !== 0 || err !== 1'b0) begin $display("FAIL clean_errs got %0d/%0d/%b want 0/0/0", sof_err, line_err, err); miscompares++; end vectors++;
    if (last_beats !== 10) begin $display("FAIL clean_last got %0d want 10", last_beats); miscompares++; end vectors++;
    if (signature !== sig_m) begin $display("FAIL clean_sig got %h want %h", signature, sig_m); miscompares++; end vectors++;
    if (state !== 2'd1) begin $display("FAIL clean_state got %0d want 1", state); miscompares++; end vectors++;
  endtask

  task automatic test_short_line();
    pulse_clear();
    sig_m = '0;
    for (int l = 0; l < 10; l++) begin
      send_line(l == 3 ? 9 : 10, l == 0, 1'b1);
      if (l == 3) begin
        if (last_beats !== 9) begin $display("FAIL short_last got %0d want 9", last_beats); miscompares++; end vectors++;
        if (line_err !== 1 || err !== 1'b1) begin $display("FAIL short_err got %0d/%b want 1/1", line_err, err); miscompares++; end vectors++;
      end
    end
    if (frame_count !== 1 || line_err !== 1) begin $display("FAIL short_frame got %0d/%0d want 1/1", frame_count, line_err); miscompares++; end vectors++;
    if (last_beats !== 10 || signature !== sig_m) begin $display("FAIL short_end got last=%0d sig=%h want 10 %h", last_beats, signature, sig_m); miscompares++; end vectors++;
  endtask

  task automatic test_early_sof();
    pulse_clear();
    send_line(10, 1'b1, 1'b1);
    send_line(10, 1'b0, 1'b1);
    send_line(10, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b0);
    send_frame();
    if (sof_err !== 1 || err !== 1'b1) begin $display("FAIL early_sof got %0d/%b want 1/1", sof_err, err); miscompares++; end vectors++;
    if (frame_count !== 1 || line_err !== 0) begin $display("FAIL early_frame got %0d/%0d want 1/0", frame_count, line_err); miscompares++; end vectors++;
    if (signature !== sig_m) begin $display("FAIL early_sig got %h want %h", signature, sig_m); miscompares++; end vectors++;
  endtask

  task automatic test_overrun();
    pulse_clear();
    send_frame();
    send_line(10, 1'b0, 1'b0);
    if (sof_err !== 1 || frame_count !== 1) begin $display("FAIL overrun_once got %0d/%0d want 1/1", sof_err, frame_count); miscompares++; end vectors++;
    if (state !== 2'd1) begin $display("FAIL overrun_state got %0d want 1", state); miscompares++; end vectors++;
    send_frame();
    if (frame_count !== 2 || sof_err !== 1) begin $display("FAIL overrun_next got %0d/%0d want 2/1", frame_count, sof_err); miscompares++; end vectors++;
    if (signature !== sig_m) begin $display("FAIL overrun_sig got %h want %h", signature, sig_m); miscompares++; end vectors++;
  endtask

  task automatic test_enable_mid();
    enable = 1'b0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int l = 0; l < 3; l++) send_line(10, l == 0, 1'b1);
    enable = 1'b1;
    for (int l = 3; l < 10; l++) send_line(10, 1'b0, 1'b1);
    if (sof_err !== 0 || line_err !== 0 || frame_count !== 0) begin $display("FAIL enmid_pre got %0d/%0d/%0d want 0/0/0", sof_err, line_err, frame_count); miscompares++; end vectors++;
    send_frame();
    if (frame_count !== 1 || err !== 1'b0) begin $display("FAIL enmid_frame got %0d/%b want 1/0", frame_count, err); miscompares++; end vectors++;
  endtask

  task automatic test_reset_mid();
    send_line(10, 1'b1, 1'b1);
    send_line(5, 1'b0, 1'b0);
    aresetn = 1'b0;
    tick();
    if (frame_count !== 0 || last_beats !== 0 || signature !== 0) begin $display("FAIL rstmid_out got %0d/%0d/%h want 0", frame_count, last_beats, signature); miscompares++; end vectors++;
    if (state !== 2'd0) begin $display("FAIL rstmid_state got %0d want 0", state); miscompares++; end vectors++;
    aresetn = 1'b1;
    tick();
    if (state !== 2'd1) begin $display("FAIL rstmid_resume got %0d want 1", state); miscompares++; end vectors++;
  endtask

  task automatic test_clear_collide();
    send_frame();
    if (frame_count !== 1) begin $display("FAIL collide_pre got %0d want 1", frame_count); miscompares++; end vectors++;
    clear = 1'b1;
    send_line(1, 1'b0, 1'b0);
    clear = 1'b0;
    if (sof_err !== 0 || err !== 1'b0 || frame_count !== 0) begin $display("FAIL collide_clear got %0d/%b/%0d want 0/0/0", sof_err, err, frame_count); miscompares++; end vectors++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_short_line();
    test_early_sof();
    test_overrun();
    test_enable_mid();
    test_reset_mid();
    test_clear_collide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
